lfsr_arbiter: RTL and testbench

- Shares one 16-bit Fibonacci LFSR (polynomial x^16+x^14+x^13+x^11+1) between NREQ requesters in the replay-buffer datapath, e.g. scrambler seeding and retry-backoff jitter.
- Sequences the generator: seed load, zero-seed protection, warm-up flush, then round-robin issue of one pseudo-random word per grant.
- Sits between the host/config interface (seed writes) and the requesting datapath blocks.

---
 rtl/lfsr_arbiter.sv | 161 ++++++++++++++++
 tb/tb_lfsr_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lfsr_arbiter.sv
// lfsr_arbiter
//   Shares one 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) between NREQ
//   requesters. Handles seed load with zero-seed substitution and an optional
//   warm-up flush, then issues one pseudo-random word per round-robin grant.
//
// Ports
//   clk        clock, all state on rising edge
//   rst        asynchronous active-low reset
//   seed_we    load seed_data as the new LFSR state
//   seed_data  seed value
//   req        per-requester level request, sampled every cycle
//   gnt        registered one-hot grant, valid with rnd_valid
//   rnd_valid  gnt/rnd_data valid this cycle (single cycle, no back-pressure)
//   rnd_data   random word for the granted requester, holds when not valid
//   busy       high in LOAD/WARM, no grants issued
//   grant_cnt  (LFSR_ARBITER_STATS_EN only) saturating count of issued grants
//   stall_cnt  (LFSR_ARBITER_STATS_EN only) saturating count of cycles with a
//              request pending while grants are blocked (busy or seed_we)
//
// Optional feature macro: LFSR_ARBITER_STATS_EN
//
// FSM states
//   state   | meaning
//   ST_RUN  | arbitrate requests, one word per grant
//   ST_LOAD | one cycle, copy captured seed (0 -> SEED) into the LFSR
//   ST_WARM | step the LFSR WARMUP times, discarding the output
module lfsr_arbiter #(
  parameter int          NREQ   = 4,
  parameter logic [15:0] SEED   = 16'hACE1,
  parameter int          WARMUP = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            seed_we,
  input  logic [15:0]     seed_data,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            rnd_valid,
  output logic [15:0]     rnd_data,
  output logic            busy
`ifdef LFSR_ARBITER_STATS_EN
  ,
  output logic [31:0]     grant_cnt,
  output logic [15:0]     stall_cnt
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_WARM = 2'd2;

  logic [1:0]      state;
  logic [15:0]     s;
  logic [15:0]     seed_q;
  logic [PW-1:0]   rr_ptr;
  logic [7:0]      warm_cnt;

  logic [15:0]     s_next;
  logic            lo_found, hi_found, win_found;
  logic [PW-1:0]   lo_idx, hi_idx, win_idx, rr_next;
  logic [NREQ-1:0] win_onehot;
  logic            grant_issue;

  assign s_next = {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};

  // Round-robin pick: lowest request at or above rr_ptr, otherwise wrap to
  // the lowest request overall. Scanning downward lets the last hit win.
  always_comb begin
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_idx   = PW'(i);
        if (PW'(i) >= rr_ptr) begin
          hi_found = 1'b1;
          hi_idx   = PW'(i);
        end
      end
    end
    win_found = lo_found;
    win_idx   = hi_found ? hi_idx : lo_idx;
  end

  assign rr_next     = (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + PW'(1);
  assign win_onehot  = {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
  assign grant_issue = (state == ST_RUN) && !seed_we && win_found;
  assign busy        = (state != ST_RUN);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      s         <= SEED;
      seed_q    <= '0;
      rr_ptr    <= '0;
      warm_cnt  <= '0;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
    end else begin
      if (seed_we) seed_q <= seed_data;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      case (state)
        ST_RUN: begin
          if (seed_we) begin
            state <= ST_LOAD;
          end else if (win_found) begin
            gnt       <= win_onehot;
            rnd_valid <= 1'b1;
            rnd_data  <= s;
            s         <= s_next;
            rr_ptr    <= rr_next;
          end
        end
        ST_LOAD: begin
          s <= (seed_q == 16'h0000) ? SEED : seed_q;
          // A fresh seed write arriving here is reloaded on the next cycle.
          if (seed_we) begin
            state <= ST_LOAD;
          end else if (WARMUP > 0) begin
            state    <= ST_WARM;
            warm_cnt <= 8'(WARMUP);
          end else begin
            state <= ST_RUN;
          end
        end
        ST_WARM: begin
          s <= s_next;
          if (seed_we) begin
            state <= ST_LOAD;
          end else if (warm_cnt == 8'd1) begin
            state <= ST_RUN;
          end else begin
            warm_cnt <= warm_cnt - 8'd1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

`ifdef LFSR_ARBITER_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      grant_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (grant_issue && (grant_cnt != 32'hFFFF_FFFF))
        grant_cnt <= grant_cnt + 32'd1;
      if ((|req) && (busy || seed_we) && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lfsr_arbiter.sv
// tb_lfsr_arbiter
//   Two instances share stimulus: u_dut0 (WARMUP=0) and u_dut2 (WARMUP=2).
//   A cycle model pushes expected outputs into per-instance queues at each
//   rising edge; the falling edge pops and compares. Directed anchors check
//   the known LFSR words and grant orders.
module tb_lfsr_arbiter;

  localparam logic [15:0] SEED = 16'hACE1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        seed_we = 1'b0;
  logic [15:0] seed_data = 16'h0000;
  logic [3:0]  req = 4'b0000;

  logic [3:0]  gnt0, gnt2;
  logic        v0, v2, b0, b2;
  logic [15:0] d0, d2;
`ifdef LFSR_ARBITER_STATS_EN
  logic [31:0] gc0, gc2;
  logic [15:0] sc0, sc2;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lfsr_arbiter #(.NREQ(4), .SEED(SEED), .WARMUP(0)) u_dut0 (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed_data(seed_data), .req(req),
    .gnt(gnt0), .rnd_valid(v0), .rnd_data(d0), .busy(b0)
`ifdef LFSR_ARBITER_STATS_EN
    , .grant_cnt(gc0), .stall_cnt(sc0)
`endif
  );

  lfsr_arbiter #(.NREQ(4), .SEED(SEED), .WARMUP(2)) u_dut2 (
    .clk(clk), .rst(rst), .seed_we(seed_we), .seed_data(seed_data), .req(req),
    .gnt(gnt2), .rnd_valid(v2), .rnd_data(d2), .busy(b2)
`ifdef LFSR_ARBITER_STATS_EN
    , .grant_cnt(gc2), .stall_cnt(sc2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] step_f(input logic [15:0] v);
    return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
  endfunction

  // ---------------- reference model ----------------
  typedef struct {
    logic [3:0]  gnt;
    logic        valid;
    logic [15:0] data;
    logic        busy;
    logic [31:0] gcnt;
  } exp_t;

  exp_t q0[$];
  exp_t q2[$];

  logic [1:0]  m_st[2];
  logic [15:0] m_s[2];
  logic [15:0] m_sq[2];
  logic [15:0] m_data[2];
  logic [1:0]  m_rr[2];
  logic [7:0]  m_cnt[2];
  logic [3:0]  m_gnt[2];
  logic        m_v[2];
  logic [31:0] m_gc[2];
  int          m_w[2] = '{0, 2};

  task automatic model_reset(input int k);
    m_st[k] = 2'd0; m_s[k] = SEED; m_sq[k] = 16'h0; m_data[k] = 16'h0;
    m_rr[k] = 2'd0; m_cnt[k] = 8'd0; m_gnt[k] = 4'b0; m_v[k] = 1'b0; m_gc[k] = 0;
  endtask

  task automatic model_step(input int k);
    logic [15:0] sq_n;
    int win;
    sq_n = seed_we ? seed_data : m_sq[k];
    m_gnt[k] = 4'b0;
    m_v[k]   = 1'b0;
    case (m_st[k])
      2'd0: begin
        if (seed_we) begin
          m_st[k] = 2'd1;
        end else begin
          win = -1;
          for (int j = 0; j < 4; j++)
            if (win < 0 && req[(int'(m_rr[k]) + j) % 4]) win = (int'(m_rr[k]) + j) % 4;
          if (win >= 0) begin
            m_gnt[k]  = 4'(1) << win;
            m_v[k]    = 1'b1;
            m_data[k] = m_s[k];
            m_s[k]    = step_f(m_s[k]);
            m_rr[k]   = 2'((win + 1) % 4);
            m_gc[k]++;
          end
        end
      end
      2'd1: begin
        m_s[k] = (m_sq[k] == 16'h0) ? SEED : m_sq[k];
        if (seed_we) m_st[k] = 2'd1;
        else if (m_w[k] > 0) begin m_st[k] = 2'd2; m_cnt[k] = 8'(m_w[k]); end
        else m_st[k] = 2'd0;
      end
      default: begin
        m_s[k] = step_f(m_s[k]);
        if (seed_we) m_st[k] = 2'd1;
        else if (m_cnt[k] == 8'd1) m_st[k] = 2'd0;
        else m_cnt[k] = m_cnt[k] - 8'd1;
      end
    endcase
    m_sq[k] = sq_n;
  endtask

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst) model_reset(k);
      else model_step(k);
    end
    q0.push_back('{m_gnt[0], m_v[0], m_data[0], m_st[0] != 2'd0, m_gc[0]});
    q2.push_back('{m_gnt[1], m_v[1], m_data[1], m_st[1] != 2'd0, m_gc[1]});
  end

  task automatic check_out(input int k);
    exp_t e;
    if (k == 0) begin
      e = q0.pop_front();
      chk("d0_gnt", 32'(gnt0), 32'(e.gnt));
      chk("d0_valid", 32'(v0), 32'(e.valid));
      chk("d0_data", 32'(d0), 32'(e.data));
      chk("d0_busy", 32'(b0), 32'(e.busy));
`ifdef LFSR_ARBITER_STATS_EN
      chk("d0_grant_cnt", gc0, e.gcnt);
`endif
    end else begin
      e = q2.pop_front();
      chk("d2_gnt", 32'(gnt2), 32'(e.gnt));
      chk("d2_valid", 32'(v2), 32'(e.valid));
      chk("d2_data", 32'(d2), 32'(e.data));
      chk("d2_busy", 32'(b2), 32'(e.busy));
`ifdef LFSR_ARBITER_STATS_EN
      chk("d2_grant_cnt", gc2, e.gcnt);
`endif
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) check_out(0);
    if (q2.size() > 0) check_out(1);
  end

  // ---------------- directed stimulus ----------------
  logic [3:0]  rr_gnt[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [15:0] seq_w[3]  = '{16'hACE1, 16'h5670, 16'hAB38};

  initial begin
    #1;
    chk("rst_gnt", 32'(gnt0), 0);
    chk("rst_valid", 32'(v0), 0);
    chk("rst_data", 32'(d0), 0);
    chk("rst_busy", 32'(b2), 0);

    // single requester from reset
    @(negedge clk); rst = 1'b1; req = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("solo_data", 32'(d0), 32'(seq_w[i]));
      chk("solo_gnt", 32'(gnt0), 32'(4'b0001));
      chk("solo_data_w2", 32'(d2), 32'(seq_w[i]));
    end
    req = 4'b0000;
    @(negedge clk);
    chk("idle_valid", 32'(v0), 0);
    chk("idle_hold", 32'(d0), 32'(16'hAB38));

    // all contend from reset
    #2 rst = 1'b0;
    @(negedge clk); rst = 1'b1; req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_gnt", 32'(gnt0), 32'(rr_gnt[i]));
      if (i < 3) chk("rr_data", 32'(d0), 32'(seq_w[i]));
    end

    // zero seed, WARMUP=0
    req = 4'b0001; seed_we = 1'b1; seed_data = 16'h0000;
    @(negedge clk); seed_we = 1'b0;
    chk("zs_busy", 32'(b0), 1);
    chk("zs_nogrant", 32'(v0), 0);
    @(negedge clk);
    chk("zs_busy_drop", 32'(b0), 0);
    @(negedge clk);
    chk("zs_data", 32'(d0), 32'(16'hACE1));
    chk("zs_valid", 32'(v0), 1);
    chk("zs_w2_busy", 32'(b2), 1);
    repeat (3) @(negedge clk);

    // warm-up of 2 on u_dut2
    seed_we = 1'b1; seed_data = 16'hACE1;
    @(negedge clk); seed_we = 1'b0;
    chk("warm_busy1", 32'(b2), 1);
    @(negedge clk); chk("warm_busy2", 32'(b2), 1);
    @(negedge clk); chk("warm_busy3", 32'(b2), 1);
    @(negedge clk); chk("warm_busy_drop", 32'(b2), 0);
    @(negedge clk);
    chk("warm_data", 32'(d2), 32'(16'hAB38));
    chk("warm_valid", 32'(v2), 1);

    // seed write collides with a request; rr_ptr unchanged
    req = 4'b0100; seed_we = 1'b1; seed_data = 16'h1234;
    @(negedge clk); seed_we = 1'b0;
    chk("coll_nogrant", 32'(gnt0), 0);
    chk("coll_novalid", 32'(v0), 0);
    @(negedge clk); chk("coll_busy_drop", 32'(b0), 0);
    @(negedge clk);
    chk("coll_gnt", 32'(gnt0), 32'(4'b0100));
    chk("coll_data", 32'(d0), 32'(16'h1234));

    // reset during warm-up
    req = 4'b1111; seed_we = 1'b1; seed_data = 16'hBEEF;
    @(negedge clk); seed_we = 1'b0;
    @(negedge clk);
    chk("pre_rst_busy", 32'(b2), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_gnt", 32'(gnt2), 0);
    chk("mid_rst_valid", 32'(v2), 0);
    chk("mid_rst_data", 32'(d2), 0);
    chk("mid_rst_busy", 32'(b2), 0);
`ifdef LFSR_ARBITER_STATS_EN
    chk("mid_rst_gcnt", gc2, 0);
`endif
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("post_rst_data", 32'(d2), 32'(16'hACE1));
    chk("post_rst_gnt", 32'(gnt2), 32'(4'b0001));

    // random traffic, model-checked each cycle
    for (int i = 0; i < 60; i++) begin
      req       = 4'($urandom);
      seed_we   = ($urandom_range(0, 7) == 0);
      seed_data = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      @(negedge clk);
    end
    seed_we = 1'b0; req = 4'b0000;
    @(negedge clk);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
